// File: rtl/sdram_burst_wr_fsm.sv
// rtl/sdram_burst_wr_fsm.sv - SDRAM burst write engine: ACT, WR (optional auto-precharge), PRE
module sdram_burst_wr_fsm #(
  parameter int ROW_W     = 13,
  parameter int COL_W     = 10,
  parameter int BA_W      = 2,
  parameter int DQ_W      = 16,
  parameter int BURST_LEN = 8,
  parameter int T_RCD     = 3,
  parameter int T_WR      = 2,
  parameter int T_RP      = 3,
  parameter int AUTO_PRE  = 1
) (
  input  logic                            clk,
  input  logic                            soft_rst_n,
  input  logic                            wr_en,
  input  logic [ROW_W-1:0]                row,
  input  logic [COL_W-1:0]                col,
  input  logic [BA_W-1:0]                 ba,
  input  logic [BURST_LEN*DQ_W-1:0]       wdata,
  input  logic [BURST_LEN*DQ_W/8-1:0]     wmask,
  output logic                            wr_ack,
  output logic                            wr_done,
  output logic                            busy,
  output logic [4+ROW_W+BA_W+1-1:0]       wr_bus,
  output logic [DQ_W-1:0]                 dq_out,
  output logic [DQ_W/8-1:0]               dqm,
  output logic                            out_en
);

  localparam int MW      = DQ_W / 8;
  localparam int M1      = (T_RCD > BURST_LEN) ? T_RCD : BURST_LEN;
  localparam int M2      = (T_WR > T_RP) ? T_WR : T_RP;
  localparam int MAX_CNT = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  // ACT_WAIT lasts T_RCD-1 cycles and is skipped entirely when T_RCD is 1
  localparam logic [CNT_W-1:0] RCD_END = CNT_W'((T_RCD > 1) ? T_RCD - 2 : 0);
  localparam logic [CNT_W-1:0] BL_END  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] WR_END  = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] RP_END  = CNT_W'(T_RP - 1);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACT_WAIT,
    S_WRITE,
    S_RECOVER,
    S_PRE_WAIT
  } state_t;

  state_t                        state, state_d;
  logic [CNT_W-1:0]              cnt, cnt_d;
  logic [3:0]                    cmd_q, cmd_d;
  logic [ROW_W-1:0]              a_q, a_d;
  logic [BA_W-1:0]               ba_q, ba_d;
  logic [COL_W-1:0]              col_q, col_d;
  logic [BURST_LEN*DQ_W-1:0]     sreg, sreg_d;
  logic [BURST_LEN*MW-1:0]       mreg, mreg_d;
  logic [DQ_W-1:0]               dq_d;
  logic [MW-1:0]                 dqm_d;
  logic                          oe_d, ack_d, done_d;
  logic [ROW_W-1:0]              wr_addr;

  assign wr_bus = {cmd_q, a_q, ba_q, 1'b1};

  always_comb begin
    state_d = state;
    cnt_d   = '0;
    cmd_d   = CMD_NOP;
    a_d     = a_q;
    ba_d    = ba_q;
    col_d   = col_q;
    sreg_d  = sreg;
    mreg_d  = mreg;
    dq_d    = '0;
    dqm_d   = '0;
    oe_d    = 1'b0;
    ack_d   = 1'b0;
    done_d  = 1'b0;

    wr_addr              = '0;
    wr_addr[COL_W-1:0]   = col_q;
    wr_addr[10]          = (AUTO_PRE != 0);

    // Each state decides the bus contents of the following cycle
    case (state)
      S_IDLE: begin
        if (wr_en) begin
          cmd_d   = CMD_ACT;
          a_d     = row;
          ba_d    = ba;
          col_d   = col;
          sreg_d  = wdata;
          mreg_d  = wmask;
          ack_d   = 1'b1;
          state_d = (T_RCD > 1) ? S_ACT_WAIT : S_WRITE;
        end
      end
      S_ACT_WAIT: begin
        if (cnt == RCD_END) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (cnt == '0) begin
          cmd_d = CMD_WR;
          a_d   = wr_addr;
        end
        dq_d   = sreg[DQ_W-1:0];
        dqm_d  = mreg[MW-1:0];
        oe_d   = 1'b1;
        sreg_d = sreg >> DQ_W;
        mreg_d = mreg >> MW;
        if (cnt == BL_END) state_d = S_RECOVER;
      end
      S_RECOVER: begin
        if (cnt == WR_END) begin
          state_d = S_PRE_WAIT;
          if (AUTO_PRE == 0) begin
            cmd_d = CMD_PRE;
            a_d   = '0;
          end
        end
      end
      S_PRE_WAIT: begin
        if (cnt == RP_END) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == state && state != S_IDLE) cnt_d = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge soft_rst_n) begin
    if (!soft_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cmd_q   <= CMD_NOP;
      a_q     <= '0;
      ba_q    <= '0;
      col_q   <= '0;
      sreg    <= '0;
      mreg    <= '0;
      dq_out  <= '0;
      dqm     <= '0;
      out_en  <= 1'b0;
      wr_ack  <= 1'b0;
      wr_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      ba_q    <= ba_d;
      col_q   <= col_d;
      sreg    <= sreg_d;
      mreg    <= mreg_d;
      dq_out  <= dq_d;
      dqm     <= dqm_d;
      out_en  <= oe_d;
      wr_ack  <= ack_d;
      wr_done <= done_d;
      busy    <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_sdram_burst_wr_fsm.sv
// tb/tb_sdram_burst_wr_fsm.sv - directed self-checking bench for sdram_burst_wr_fsm
module tb_sdram_burst_wr_fsm;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WRC = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;

  localparam logic [12:0]  ROW_A = 13'h1ABC;
  localparam logic [9:0]   COL_A = 10'h155;
  localparam logic [1:0]   BA_A  = 2'd2;
  localparam logic [127:0] WD_A  = {16'h8888, 16'h7777, 16'h6666, 16'h5555,
                                    16'h4444, 16'h3333, 16'h2222, 16'h1111};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         soft_rst_n, wr_en, wr_en2;
  logic [12:0]  row;
  logic [9:0]   col;
  logic [1:0]   ba;
  logic [127:0] wdata;
  logic [15:0]  wmask;
  logic [31:0]  wdata2;
  logic [3:0]   wmask2;
  logic [5:0]   en_sw, done_sw;

  logic [19:0] bus_u0, bus_u1, bus_u2;
  logic [15:0] dq_u0, dq_u1, dq_u2;
  logic [1:0]  dqm_u0, dqm_u1, dqm_u2;
  logic        oe_u0, oe_u1, oe_u2, ack_u0, ack_u1, ack_u2;
  logic        done_u0, done_u1, done_u2, busy_u0, busy_u1, busy_u2;

  sdram_burst_wr_fsm u0 (
    .clk(clk), .soft_rst_n(soft_rst_n), .wr_en(wr_en), .row(row), .col(col), .ba(ba),
    .wdata(wdata), .wmask(wmask), .wr_ack(ack_u0), .wr_done(done_u0), .busy(busy_u0),
    .wr_bus(bus_u0), .dq_out(dq_u0), .dqm(dqm_u0), .out_en(oe_u0));

  sdram_burst_wr_fsm #(.AUTO_PRE(0)) u1 (
    .clk(clk), .soft_rst_n(soft_rst_n), .wr_en(wr_en), .row(row), .col(col), .ba(ba),
    .wdata(wdata), .wmask(wmask), .wr_ack(ack_u1), .wr_done(done_u1), .busy(busy_u1),
    .wr_bus(bus_u1), .dq_out(dq_u1), .dqm(dqm_u1), .out_en(oe_u1));

  sdram_burst_wr_fsm #(.BURST_LEN(2), .T_RCD(1)) u2 (
    .clk(clk), .soft_rst_n(soft_rst_n), .wr_en(wr_en2), .row(row), .col(col), .ba(ba),
    .wdata(wdata2), .wmask(wmask2), .wr_ack(ack_u2), .wr_done(done_u2), .busy(busy_u2),
    .wr_bus(bus_u2), .dq_out(dq_u2), .dqm(dqm_u2), .out_en(oe_u2));

  // Sweep: index g -> BURST_LEN {1,4,8}, T_WR=T_RP {1,3}
  for (genvar g = 0; g < 6; g++) begin : g_sw
    localparam int BL = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 4 : 8);
    localparam int TW = (g < 3) ? 1 : 3;
    logic [19:0] bus;
    logic [15:0] dq;
    logic [1:0]  dqm;
    logic        ack, oe, busy;
    sdram_burst_wr_fsm #(.BURST_LEN(BL), .T_WR(TW), .T_RP(TW)) u_dut (
      .clk(clk), .soft_rst_n(soft_rst_n), .wr_en(en_sw[g]), .row(row), .col(col), .ba(ba),
      .wdata({BL{16'h5A5A}}), .wmask({(2*BL){1'b0}}), .wr_ack(ack), .wr_done(done_sw[g]),
      .busy(busy), .wr_bus(bus), .dq_out(dq), .dqm(dqm), .out_en(oe));
  end

  logic [19:0] bus0 [32], bus1 [32], bus2 [32];
  logic [15:0] dq0 [32], dq2 [32];
  logic [1:0]  dqm0 [32], dqm2 [32];
  logic        oe0 [32], oe2 [32], ack0 [32], done0 [32], busy0 [32], done1 [32], done2 [32];
  logic [5:0]  dsw [32];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Records cycle c outputs at the negedge, then drives cycle c inputs; garbage when not requesting
  task automatic run(input int sel, input logic [31:0] pat, input int n);
    for (int c = 0; c < n; c++) begin
      bus0[c] = bus_u0; dq0[c] = dq_u0; dqm0[c] = dqm_u0; oe0[c] = oe_u0;
      ack0[c] = ack_u0; done0[c] = done_u0; busy0[c] = busy_u0;
      bus1[c] = bus_u1; done1[c] = done_u1;
      bus2[c] = bus_u2; dq2[c] = dq_u2; dqm2[c] = dqm_u2; oe2[c] = oe_u2; done2[c] = done_u2;
      dsw[c]  = done_sw;
      wr_en  = (sel == 0) && pat[c];
      wr_en2 = (sel == 1) && pat[c];
      en_sw  = {6{(sel == 2) && pat[c]}};
      row    = pat[c] ? ROW_A : ~ROW_A;
      col    = pat[c] ? COL_A : ~COL_A;
      ba     = pat[c] ? BA_A : ~BA_A;
      wdata  = pat[c] ? WD_A : ~WD_A;
      wmask  = pat[c] ? 16'h0000 : 16'hFFFF;
      wdata2 = pat[c] ? {16'hBEEF, 16'hCAFE} : 32'h0;
      wmask2 = pat[c] ? 4'b1000 : 4'b1111;
      @(negedge clk);
    end
  endtask

  logic [31:0] m_oe, m_cmd, m_ack, m_done, m_busy, m_cke, m_dqm, m_cmd1, m_done1, m_oe2, m_done2;
  int          exp_sw [6] = '{6, 9, 13, 10, 13, 17};
  int          got_sw;

  task automatic masks(input int n);
    m_oe = 0; m_cmd = 0; m_ack = 0; m_done = 0; m_busy = 0; m_cke = 0; m_dqm = 0;
    m_cmd1 = 0; m_done1 = 0; m_oe2 = 0; m_done2 = 0;
    for (int c = 0; c < n; c++) begin
      m_oe[c]    = oe0[c];
      m_cmd[c]   = (bus0[c][19:16] != NOP);
      m_ack[c]   = ack0[c];
      m_done[c]  = done0[c];
      m_busy[c]  = busy0[c];
      m_cke[c]   = bus0[c][0];
      m_dqm[c]   = (dqm0[c] != 2'b00);
      m_cmd1[c]  = (bus1[c][19:16] != NOP);
      m_done1[c] = done1[c];
      m_oe2[c]   = oe2[c];
      m_done2[c] = done2[c];
    end
  endtask

  initial begin
    soft_rst_n = 1'b0;
    run(3, 32'h0, 3);
    check("rst_bus", bus_u0, 20'h70001);
    check("rst_misc", {dq_u0, dqm_u0, oe_u0, ack_u0, done_u0, busy_u0}, 0);
    soft_rst_n = 1'b1;
    @(negedge clk);

    run(0, 32'h1, 24);
    masks(24);
    check("act_cmd", bus0[1][19:16], ACT);
    check("act_row", bus0[1][15:3], ROW_A);
    check("act_ba", bus0[1][2:1], BA_A);
    check("wr_cmd", bus0[4][19:16], WRC);
    check("wr_addr_ap", bus0[4][15:3], 13'h0555);
    for (int k = 0; k < 8; k++) check($sformatf("beat%0d", k), dq0[4+k], 32'h1111 * (k + 1));
    check("oe_window", m_oe, 32'h0000_0FF0);
    check("cmd_cycles", m_cmd, 32'h0000_0012);
    check("ack_cycle", m_ack, 32'h0000_0002);
    check("done_cycle", m_done, 32'h0001_0000);
    check("busy_window", m_busy, 32'h0000_FFFE);
    check("cke_high", m_cke, 32'h00FF_FFFF);
    check("dqm_zero", m_dqm, 32'h0);
    check("np_wr_addr", bus1[4][15:3], 13'h0155);
    check("np_cmd_cycles", m_cmd1, 32'h0000_2012);
    check("np_pre_cmd", bus1[13][19:16], PRE);
    check("np_pre_ba", bus1[13][2:1], BA_A);
    check("np_pre_a10", bus1[13][13], 1'b0);
    check("np_done_cycle", m_done1, 32'h0001_0000);

    run(1, 32'h1, 16);
    masks(16);
    check("bl2_act", bus2[1][19:16], ACT);
    check("bl2_wr", bus2[2][19:16], WRC);
    check("bl2_beat0", {dq2[2], dqm2[2]}, {16'hCAFE, 2'b00});
    check("bl2_beat1", {dq2[3], dqm2[3]}, {16'hBEEF, 2'b10});
    check("bl2_dqm_after", dqm2[4], 2'b00);
    check("bl2_oe", m_oe2, 32'h0000_000C);
    check("bl2_done", m_done2, 32'h0000_0100);

    run(0, 32'hFFFF_FFFF, 20);
    masks(20);
    check("b2b_ack", m_ack, 32'h0002_0002);
    check("b2b_act2", bus0[17][19:16], ACT);
    run(0, 32'h0, 20);

    run(0, 32'h0000_2AA9, 24);
    masks(24);
    check("toggle_ack", m_ack, 32'h0000_0002);
    check("toggle_done", m_done, 32'h0001_0000);

    run(0, 32'h1, 7);
    check("pre_rst_oe", oe0[6], 1'b1);
    soft_rst_n = 1'b0;
    #1;
    check("rst_mid_cmd", bus_u0[19:16], NOP);
    check("rst_mid_outs", {dq_u0, oe_u0, busy_u0, bus_u0[0]}, {16'h0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    soft_rst_n = 1'b1;
    run(0, 32'h1, 24);
    masks(24);
    check("rst_act", bus0[1][19:0], {ACT, ROW_A, BA_A, 1'b1});
    check("rst_wr", bus0[4][19:16], WRC);
    check("rst_ack", m_ack, 32'h0000_0002);
    check("rst_done", m_done, 32'h0001_0000);

    run(2, 32'h1, 24);
    for (int g = 0; g < 6; g++) begin
      got_sw = -1;
      for (int c = 23; c >= 0; c--) if (dsw[c][g]) got_sw = c;
      check($sformatf("sweep%0d_done", g), got_sw, exp_sw[g]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_burst_wr_fsm.md
Name: sdram_burst_wr_fsm

Overview:
Parametrised SDRAM write engine for the SDR controller, issuing ACT, WR (optional auto-precharge) and PRE on the shared command/address bus. It generalises the fixed two-beat writer: configurable burst length, data width and tRCD/tWR/tRP, per-byte write masks, and explicit- or auto-precharge modes. It sits under the controller arbiter, beside the read and refresh FSMs, and its bus is muxed onto the SDRAM pins.

Parameters:
ROW_W, 13, row address width (= SDRAM A-bus width)
COL_W, 10, column address width (must be <= 10)
BA_W, 2, bank address width
DQ_W, 16, SDRAM data width (multiple of 8)
BURST_LEN, 8, beats per write; one of 1, 2, 4, 8; must match the SDRAM mode register
T_RCD, 3, ACT-to-WR cycles (>= 1)
T_WR, 2, last-beat-to-precharge cycles (>= 1)
T_RP, 3, precharge-to-done cycles (>= 1)
AUTO_PRE, 1, 1 = WR carries A10=1; 0 = explicit PRE command

Ports:
clk  in  1  controller clock (100 MHz)
soft_rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request, level, sampled in IDLE
row  in  ROW_W  row address
col  in  COL_W  column address
ba  in  BA_W  bank address
wdata  in  BURST_LEN*DQ_W  burst data, beat k = wdata[k*DQ_W +: DQ_W]
wmask  in  BURST_LEN*DQ_W/8  byte masks, 1 = byte not written, beat k = wmask[k*DQ_W/8 +: DQ_W/8]
wr_ack  out  1  one-cycle pulse: request accepted, inputs captured
wr_done  out  1  one-cycle pulse: write and precharge timing complete
busy  out  1  high in every state except IDLE
wr_bus  out  4+ROW_W+BA_W+1  {cmd[3:0], a[ROW_W-1:0], ba, cke}; command codes from the shared SDRAM command header
dq_out  out  DQ_W  write data toward the pad tristate
dqm  out  DQ_W/8  byte masks aligned with dq_out
out_en  out  1  tristate enable for dq_out

Behaviour:
- Reset (async, any state): state=IDLE; cmd=NOP, a=0, ba=0, cke=1; dq_out=0, dqm=0, out_en=0; wr_ack=wr_done=busy=0; counters 0. No PRE is issued for an interrupted burst. The bank stays open, and the controller's reinit path owns recovery.
- All outputs are registered. Cycle 0 is the IDLE cycle where wr_en=1 is sampled.
- At the cycle-0 edge: row, col, ba, wdata and wmask are captured; wr_ack is high in cycle 1. Inputs may change from cycle 1.
- Cycle 1: cmd=ACT, a=row, ba=ba.
- Cycles 2..T_RCD: NOP.
- Cycle T_RCD+1: cmd=WR, a[COL_W-1:0]=col, a[10]=AUTO_PRE, other a bits 0.
- Data beats: beat k drives dq_out and dqm in cycle T_RCD+1+k, for k=0..BURST_LEN-1, with out_en=1 throughout. Commands are NOP after WR.
- Let L = T_RCD+BURST_LEN, the last beat cycle. From L+1, out_en=0 and dqm=0.
- AUTO_PRE=0: cmd=PRE in cycle L+T_WR, with a[10]=0 and ba = captured bank.
- AUTO_PRE=1: NOP only.
- wr_done is high in cycle L+T_WR+T_RP. The FSM is in IDLE that same cycle, so a wr_en sampled then is accepted (back-to-back).
- Address and ba hold their last value during NOP cycles. cke is always 1.
- States: IDLE -> ACT_WAIT (counts T_RCD-1) -> WRITE (counts BURST_LEN) -> RECOVER (counts T_WR) -> PRE_WAIT (counts T_RP) -> IDLE.
  - The PRE command is emitted on the RECOVER->PRE_WAIT boundary when AUTO_PRE=0.
  - With T_RCD=1, WR immediately follows ACT.
- Counter width: $clog2 of max(T_RCD, BURST_LEN, T_WR, T_RP)+1. The counter clears on every state change.
- wr_en is ignored while busy; it is not queued, so the arbiter must hold it. wr_en and soft_rst_n deasserting together leaves the FSM in IDLE.
- Beat data comes from an internal shift register loaded at acceptance, shifting one DQ_W word per beat. Mask bits shift in lockstep.

Test Plan:
- Default params, row=0x1ABC, col=0x155, ba=2, wdata beats 0x1111..0x8888, wmask=0:
  - ACT in c1 with a=0x1ABC, ba=2; WR in c4 with a[9:0]=0x155, a[10]=1.
  - Beats 0x1111..0x8888 in c4..c11; out_en exactly c4..c11.
  - No PRE; wr_ack in c1, wr_done in c16.
- AUTO_PRE=0, same stimulus: WR has a[10]=0; PRE in c13 with ba=2, a[10]=0; wr_done in c16.
- BURST_LEN=2, T_RCD=1, wmask beat1=2'b10: ACT c1, WR c2; beat1 in c3 with dqm=2'b10; wr_done in c8.
- wr_en held high continuously: second ACT appears in c17. wr_en toggled during busy: no extra wr_ack.
- soft_rst_n pulsed low mid-burst (c7): outputs reach reset values immediately (cmd=NOP, out_en=0). After release, a new request starts cleanly from ACT.
- Parameter sweep over BURST_LEN {1,4,8} and T_WR/T_RP {1,3}: wr_done cycle equals T_RCD+BURST_LEN+T_WR+T_RP.
